// File: rtl/fpu_rptr_pipe.sv
// Registered repeater pipeline for long FPU datapath routes: STAGES register
// slices with valid/ready handshake, bubble collapse, flush and occupancy.

module fpu_rptr_stage #(
    parameter int WIDTH = 64
) (
    input  logic             rclk,
    input  logic             arst,
    input  logic             flush,
    input  logic             ld,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // Payload only moves when a real entry lands here, so idle slices keep
    // their wires quiet on the long route.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (flush)
                vld <= 1'b0;
            else if (ld)
                vld <= up_vld;
            if (ld && up_vld && !flush)
                dat <= up_dat;
        end
    end

endmodule

module fpu_rptr_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int OCCW   = 4
) (
    input  logic             rclk,
    input  logic             arst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    output logic [OCCW-1:0]  occ
);

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            adv;
    logic [STAGES-1:0]            ld;
    logic [STAGES-1:0]            up_vld;
    logic [STAGES-1:0][WIDTH-1:0] dat;

    // Ready chain walks from the head back to stage 0 in one process; a stage
    // can load whenever the stage below can take (ld[i+1]), which is what lets
    // bubbles collapse while out_rdy is low.
    always_comb begin
        logic dn_free;
        dn_free = out_rdy;
        adv     = '0;
        ld      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]  = vld[i] & dn_free;
            ld[i]   = ~vld[i] | adv[i];
            dn_free = ld[i];
        end
    end

    assign in_rdy = ld[0] & ~flush;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign up_vld[i] = in_vld & in_rdy;
                fpu_rptr_stage #(.WIDTH(WIDTH)) u_stage (
                    .rclk   (rclk),
                    .arst   (arst),
                    .flush  (flush),
                    .ld     (ld[i]),
                    .up_vld (up_vld[i]),
                    .up_dat (in_data),
                    .vld    (vld[i]),
                    .dat    (dat[i])
                );
            end else begin : g_body
                assign up_vld[i] = adv[i-1];
                fpu_rptr_stage #(.WIDTH(WIDTH)) u_stage (
                    .rclk   (rclk),
                    .arst   (arst),
                    .flush  (flush),
                    .ld     (ld[i]),
                    .up_vld (up_vld[i]),
                    .up_dat (dat[i-1]),
                    .vld    (vld[i]),
                    .dat    (dat[i])
                );
            end
        end
    endgenerate

    assign out_vld  = vld[STAGES-1] & ~flush;
    assign out_data = dat[STAGES-1];

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++)
            occ = occ + OCCW'(vld[i]);
    end

endmodule

// File: tb/tb_fpu_rptr_pipe.sv
// Directed bench for fpu_rptr_pipe (STAGES=3): reset, streaming latency,
// backpressure fill, bubble collapse, flush, async reset and a random soak.

module tb_fpu_rptr_pipe;

    localparam int W  = 64;
    localparam int ST = 3;

    logic          rclk = 1'b0;
    logic          arst;
    logic          flush;
    logic          in_vld;
    logic [W-1:0]  in_data;
    logic          in_rdy;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic          out_rdy;
    logic [3:0]    occ;

    int            checks = 0;
    int            errors = 0;
    int            npop   = 0;
    logic [W-1:0]  q[$];

    fpu_rptr_pipe #(.WIDTH(W), .STAGES(ST), .OCCW(4)) dut (
        .rclk     (rclk),
        .arst     (arst),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .occ      (occ)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge against the in-order queue model,
    // then apply the transfers at the edge. ev: expected out_vld, -1 = any.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input int ev);
        logic ir_exp, it, ot;
        in_vld = v; in_data = d; out_rdy = r; flush = f;
        @(negedge rclk);
        ir_exp = !f && (q.size() < ST || r);
        chk("in_rdy", {63'd0, in_rdy}, {63'd0, ir_exp});
        chk("occ", {60'd0, occ}, W'(q.size()));
        chk("occ_le_stages", {63'd0, occ <= 4'(ST)}, 64'd1);
        if (f || q.size() == 0)
            chk("out_vld_idle", {63'd0, out_vld}, 64'd0);
        if (ev >= 0)
            chk("out_vld", {63'd0, out_vld}, W'(ev));
        if (out_vld && q.size() != 0)
            chk("out_data", out_data, q[0]);
        it = v & ir_exp;
        ot = out_vld & r & (q.size() != 0);
        @(posedge rclk);
        if (f)
            q.delete();
        else begin
            if (ot) begin
                void'(q.pop_front());
                npop++;
            end
            if (it)
                q.push_back(d);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int p0;
        arst = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;

        // Reset asserted mid-cycle takes effect immediately.
        #3 arst = 1'b1;
        #1;
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_occ", {60'd0, occ}, 64'd0);
        chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        @(posedge rclk); @(posedge rclk); #1;
        arst = 1'b0;
        repeat (2) begin
            @(negedge rclk);
            chk("idle_out_vld", {63'd0, out_vld}, 64'd0);
            chk("idle_out_data", out_data, 64'd0);
            chk("idle_occ", {60'd0, occ}, 64'd0);
            chk("idle_in_rdy", {63'd0, in_rdy}, 64'd1);
            @(posedge rclk); #1;
        end

        // Streaming 0x1..0x10: head visible after the 3rd edge, occ steady at 3.
        for (int c = 0; c < 20; c++)
            cyc(c < 16, W'(c + 1), 1'b1, 1'b0, (c >= 3 && c <= 18) ? 1 : 0);
        chk("stream_count", W'(npop), 64'd16);

        // Backpressure: fill with out_rdy=0, then release and drain 0xA0..0xA5.
        acc = 0; p0 = npop;
        for (int c = 0; c < 5; c++) begin
            logic take;
            take = q.size() < ST;
            cyc(1'b1, 64'hA0 + W'(acc), 1'b0, 1'b0, (c >= 3) ? 1 : 0);
            if (take) acc++;
        end
        chk("bp_full_occ", {60'd0, occ}, 64'd3);
        chk("bp_full_in_rdy", {63'd0, in_rdy}, 64'd0);
        for (int c = 0; c < 20; c++) begin
            if (acc < 6) begin
                cyc(1'b1, 64'hA0 + W'(acc), 1'b1, 1'b0, -1);
                acc++;
            end else
                cyc(1'b0, '0, 1'b1, 1'b0, -1);
        end
        chk("bp_drained", W'(npop - p0), 64'd6);

        // Bubble collapse: alternate inserts while stalled still fill all stages.
        for (int c = 0; c < 6; c++)
            cyc(c % 2 == 0, 64'hB0 + W'(c), 1'b0, 1'b0, -1);
        cyc(1'b1, 64'hBF, 1'b0, 1'b0, 1);
        chk("bubble_occ", {60'd0, occ}, 64'd3);

        // Flush with in_vld and out_rdy high: nothing moves, then 0x55 flows.
        p0 = npop;
        cyc(1'b1, 64'hDEAD, 1'b1, 1'b1, 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 0);
        chk("flush_no_pop", W'(npop - p0), 64'd0);
        cyc(1'b1, 64'h55, 1'b1, 1'b0, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, 0);
        chk("flush_then_55", W'(npop - p0), 64'd1);

        // Async reset while entries are in flight.
        cyc(1'b1, 64'hC1, 1'b0, 1'b0, -1);
        cyc(1'b1, 64'hC2, 1'b0, 1'b0, -1);
        in_vld = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("mid_rst_occ", {60'd0, occ}, 64'd0);
        chk("mid_rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        chk("mid_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        q.delete();
        @(posedge rclk); #1;
        arst = 1'b0;

        // Random soak against the queue model.
        for (int c = 0; c < 400; c++)
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, -1);
        for (int c = 0; c < 6; c++)
            cyc(1'b0, '0, 1'b1, 1'b0, -1);
        chk("soak_drained", {60'd0, occ}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
